// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding,
// default geometry and the slice-counter width helper.
package sub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must index NSLICE slices; keep at least one bit so a
    // single-slice configuration still has a legal vector.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sub_slice.sv
// One SLICE-bit subtract step with borrow in/out. Purely combinational;
// the top reuses a single instance for every slice position.
module sub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             bin,
    output logic [SLICE-1:0] d_s,
    output logic             bout
);

    logic [SLICE:0] wide;

    // Extend by one bit: the extra MSB goes to 1 exactly when the slice
    // result is negative, which is the borrow into the next slice.
    always_comb begin
        wide = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, bin};
        d_s  = wide[SLICE-1:0];
        bout = wide[SLICE];
    end

endmodule

// File: rtl/sub_32bit_serial.sv
// Multi-cycle subtractor: diff = a - b, one SLICE-bit slice per clock,
// LSB slice first, with a registered borrow between slices.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE, out_valid only in DONE;
// the result holds stable in DONE until out_ready is seen.
module sub_32bit_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);

    localparam logic [1:0]    IDLE = ST_IDLE;
    localparam logic [1:0]    BUSY = ST_BUSY;
    localparam logic [1:0]    DONE = ST_DONE;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_geometry
            $error("sub_32bit_serial: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             borrow_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;
    logic             ovf_r;

    int               idx;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] d_slice;
    logic             bout;

    // Select the operand slice addressed by the counter.
    always_comb begin
        idx     = int'(cnt) * SLICE;
        a_slice = a_r[idx +: SLICE];
        b_slice = b_r[idx +: SLICE];
    end

    sub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_s  (a_slice),
        .b_s  (b_slice),
        .bin  (borrow_r),
        .d_s  (d_slice),
        .bout (bout)
    );

    // FSM plus datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            borrow_r     <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        cnt      <= '0;
                        borrow_r <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    diff_r[idx +: SLICE] <= d_slice;
                    borrow_r             <= bout;
                    if (cnt == LAST) begin
                        // Final slice carries the result MSB, so signed
                        // overflow is decided from this slice's top bit.
                        borrow_out_r <= bout;
                        ovf_r        <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                        (d_slice[SLICE-1] != a_r[WIDTH-1]);
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decoded directly from state so reset is visible immediately.
    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
        diff       = diff_r;
        borrow_out = borrow_out_r;
        ovf        = ovf_r;
    end

endmodule

// File: tb/tb_sub_32bit_serial.sv
// Bench for sub_32bit_serial: directed corner cases, backpressure,
// asynchronous reset mid-operation and randomized operands.
module tb_sub_32bit_serial;

  localparam int W      = 32;
  localparam int NSLICE = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;

  // Expected entries: {ovf, borrow_out, diff}
  logic [W+1:0] exp_q[$];

  sub_32bit_serial dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-range values.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint ua, ub, sa, sb, s;
    logic   bo, ov;
    logic [W-1:0] d;
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    s  = sa - sb;
    d  = W'(ua - ub);
    bo = (ua < ub);
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ov, bo, d};
  endfunction

  // driver: present operands, complete the input handshake on one edge
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W+1:0] e);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_start", 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // wait for DONE, check latency and result against the scoreboard head
  task automatic wait_done(input string tag, output logic [W+1:0] e);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NSLICE));
    e = exp_q.pop_front();
    check({tag, "_diff"}, diff, e[W-1:0]);
    check({tag, "_borrow"}, 32'(borrow_out), 32'(e[W]));
    check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_result(input string tag, input logic [W+1:0] e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_diff_retained"}, diff, e[W-1:0]);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W+1:0] e);
    logic [W+1:0] got;
    start_op(ta, tb_v, e);
    wait_done(tag, got);
    release_result(tag, got);
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] ra, rb;

    // reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases, expected values written out by hand
    run_op("t1", 32'h0000_0005, 32'h0000_0003, {1'b0, 1'b0, 32'h0000_0002});
    run_op("t2", 32'h0000_0100, 32'h0000_0001, {1'b0, 1'b0, 32'h0000_00FF});
    run_op("t3", 32'h0000_0000, 32'h0000_0001, {1'b0, 1'b1, 32'hFFFF_FFFF});
    run_op("t4a", 32'h8000_0000, 32'h0000_0001, {1'b1, 1'b0, 32'h7FFF_FFFF});
    run_op("t4b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, {1'b1, 1'b1, 32'h8000_0000});

    // backpressure: hold the result while in_valid and operands wiggle
    start_op(32'h1234_5678, 32'h0FED_CBA9, {1'b0, 1'b0, 32'h0246_8ACF});
    wait_done("bp", e);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff_stable", diff, e[W-1:0]);
      check("bp_borrow_stable", 32'(borrow_out), 32'(e[W]));
      check("bp_ovf_stable", 32'(ovf), 32'(e[W+1]));
    end
    in_valid = 1'b0;
    release_result("bp", e);
    @(posedge clk); #1;
    check("bp_no_new_op", 32'(busy), 32'd0);

    // asynchronous reset while the counter sits at 2
    start_op(32'hDEAD_BEEF, 32'h0123_4567, model(32'hDEAD_BEEF, 32'h0123_4567));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ar_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_diff", diff, 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_borrow", 32'(borrow_out), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("t6", 32'd10, 32'd20, {1'b0, 1'b1, 32'hFFFF_FFF6});

    // randomized operands against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) rb = ra;
      if (i % 6 == 1) ra = {1'b1, 31'(ra)};
      run_op("rnd", ra, rb, model(ra, rb));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        @(posedge clk); #1;
      end
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
